// File: rtl/fetch_prefetch_queue.sv
// fetch_prefetch_queue: in-order instruction prefetch buffer with redirect and
// discard of responses that were already in flight when the PC was redirected.
module fetch_prefetch_queue #(
    parameter int              XLEN     = 32,
    parameter int              DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            reset,
    output logic            code_req,
    output logic [XLEN-1:0] code_addr_bus,
    input  logic            code_req_ready,
    input  logic [31:0]     code_data_bus,
    input  logic            code_data_already,
    input  logic            load_pc_en,
    input  logic [XLEN-1:0] load_pc,
    output logic [31:0]     ir,
    output logic [XLEN-1:0] pc_to_DECODE,
    output logic            ir_already,
    input  logic            ir_take,
    output logic            resp_err
);
    localparam int AW = $clog2(DEPTH);
    // in-flight total covers live words plus dropped ones, each bounded by DEPTH
    localparam int CW = AW + 2;

    logic [XLEN-1:0]  fetch_pc_q, fetch_pc_d;
    logic [XLEN-1:0]  pc_q [DEPTH];
    logic [31:0]      data_q [DEPTH];
    logic [DEPTH-1:0] valid_q, valid_d;
    logic [AW-1:0]    alloc_q, alloc_d, fill_q, fill_d, head_q, head_d;
    logic [AW:0]      occ_q, occ_d;
    logic [CW-1:0]    out_cnt_q, out_cnt_d, drop_cnt_q, drop_cnt_d;
    logic             resp_err_q, resp_err_d;
    logic             accept, resp_ok, fill, pop;

    assign code_req      = !reset && !load_pc_en && (occ_q < (AW+1)'(DEPTH));
    assign accept        = code_req && code_req_ready;
    assign resp_ok       = code_data_already && (out_cnt_q != '0);
    assign fill          = resp_ok && (drop_cnt_q == '0) && !load_pc_en;
    assign pop           = valid_q[head_q] && ir_take && !load_pc_en;
    assign code_addr_bus = fetch_pc_q;
    assign ir            = data_q[head_q];
    assign pc_to_DECODE  = pc_q[head_q];
    assign ir_already    = valid_q[head_q];
    assign resp_err      = resp_err_q;

    always_comb begin
        fetch_pc_d = load_pc_en ? (load_pc & ~XLEN'(3)) : accept ? fetch_pc_q + XLEN'(4) : fetch_pc_q;
        alloc_d    = load_pc_en ? '0 : alloc_q + AW'(accept);
        fill_d     = load_pc_en ? '0 : fill_q + AW'(fill);
        head_d     = load_pc_en ? '0 : head_q + AW'(pop);
        occ_d      = load_pc_en ? '0 : occ_q + (AW+1)'(accept) - (AW+1)'(pop);
        out_cnt_d  = out_cnt_q + CW'(accept) - CW'(resp_ok);
        drop_cnt_d = load_pc_en ? out_cnt_q - CW'(resp_ok)
                                : drop_cnt_q - CW'(resp_ok && (drop_cnt_q != '0));
        resp_err_d = resp_err_q || (code_data_already && (out_cnt_q == '0));
        valid_d    = valid_q;
        if (load_pc_en)
            valid_d = '0;
        else begin
            if (fill)
                valid_d[fill_q] = 1'b1;
            if (pop)
                valid_d[head_q] = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_pc_q <= RESET_PC;
            valid_q    <= '0;
            alloc_q    <= '0;
            fill_q     <= '0;
            head_q     <= '0;
            occ_q      <= '0;
            out_cnt_q  <= '0;
            drop_cnt_q <= '0;
            resp_err_q <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                pc_q[i]   <= '0;
                data_q[i] <= '0;
            end
        end else begin
            fetch_pc_q <= fetch_pc_d;
            valid_q    <= valid_d;
            alloc_q    <= alloc_d;
            fill_q     <= fill_d;
            head_q     <= head_d;
            occ_q      <= occ_d;
            out_cnt_q  <= out_cnt_d;
            drop_cnt_q <= drop_cnt_d;
            resp_err_q <= resp_err_d;
            if (accept)
                pc_q[alloc_q] <= fetch_pc_q;
            if (fill)
                data_q[fill_q] <= code_data_bus;
        end
    end
endmodule

// File: tb/tb_fetch_prefetch_queue.sv
// tb_fetch_prefetch_queue: bench acts as code bus and DECODE; a queue-level model
// of in-flight and buffered words is compared with the DUT every cycle.
module tb_fetch_prefetch_queue;
    localparam int DEPTH = 4;

    logic        clk = 0;
    logic        reset = 1;
    logic        code_req;
    logic [31:0] code_addr_bus;
    logic        code_req_ready = 0;
    logic [31:0] code_data_bus = 0;
    logic        code_data_already = 0;
    logic        load_pc_en = 0;
    logic [31:0] load_pc = 0;
    logic [31:0] ir;
    logic [31:0] pc_to_DECODE;
    logic        ir_already;
    logic        ir_take = 0;
    logic        resp_err;

    fetch_prefetch_queue #(.XLEN(32), .DEPTH(DEPTH), .RESET_PC(32'h0)) dut (
        .clk(clk), .reset(reset), .code_req(code_req), .code_addr_bus(code_addr_bus),
        .code_req_ready(code_req_ready), .code_data_bus(code_data_bus),
        .code_data_already(code_data_already), .load_pc_en(load_pc_en), .load_pc(load_pc),
        .ir(ir), .pc_to_DECODE(pc_to_DECODE), .ir_already(ir_already), .ir_take(ir_take),
        .resp_err(resp_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic        drop;
    } inf_t;

    inf_t        inflight[$];
    logic [31:0] bpc[$];
    logic [31:0] bdata[$];
    logic [31:0] m_fetch = 0;
    logic        m_err = 0;
    int          n_chk = 0, n_pass = 0, n_acc = 0;
    int          rdy_mode = 0, take_mode = 0, resp_mode = 0;
    bit          spur = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    endtask

    task automatic step();
        int   live;
        logic exp_req, acc, pop;
        inf_t e;
        code_req_ready    = rdy_mode == 2 ? 1'($urandom_range(0, 1)) : (rdy_mode == 1);
        ir_take           = take_mode == 2 ? 1'($urandom_range(0, 1)) : (take_mode == 1);
        code_data_already = !reset && (spur || (inflight.size() > 0 &&
                            (resp_mode == 1 || (resp_mode == 2 && $urandom_range(0, 1) == 1))));
        code_data_bus     = $urandom;
        #1;
        live = 0;
        foreach (inflight[i]) if (!inflight[i].drop) live++;
        exp_req = !reset && !load_pc_en && (bpc.size() + live < DEPTH);
        if (reset) chk("req_in_reset", code_req, 0);
        else begin
            chk("code_req", code_req, exp_req);
            chk("code_addr", code_addr_bus, m_fetch);
            chk("ir_already", ir_already, bpc.size() != 0);
            if (bpc.size() != 0) begin
                chk("pc_to_DECODE", pc_to_DECODE, bpc[0]);
                chk("ir", ir, bdata[0]);
            end
            chk("resp_err", resp_err, m_err);
        end
        if (code_req && code_req_ready) n_acc++;
        if (reset) begin
            inflight.delete(); bpc.delete(); bdata.delete();
            m_fetch = 0; m_err = 0;
        end else begin
            acc = exp_req && code_req_ready;
            pop = !load_pc_en && bpc.size() != 0 && ir_take;
            if (pop) begin
                void'(bpc.pop_front()); void'(bdata.pop_front());
            end
            if (code_data_already) begin
                if (inflight.size() == 0) m_err = 1;
                else begin
                    e = inflight.pop_front();
                    if (!e.drop && !load_pc_en) begin
                        bpc.push_back(e.pc); bdata.push_back(code_data_bus);
                    end
                end
            end
            if (acc) begin
                e.pc = m_fetch; e.drop = 0;
                inflight.push_back(e);
                m_fetch = m_fetch + 4;
            end
            if (load_pc_en) begin
                bpc.delete(); bdata.delete();
                foreach (inflight[i]) inflight[i].drop = 1;
                m_fetch = load_pc & ~32'd3;
            end
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset = 1; spur = 0; load_pc_en = 0;
        rdy_mode = 0; resp_mode = 0; take_mode = 0;
        step(); step();
        reset = 0; n_acc = 0;
    endtask

    task automatic wait_ir(input int bound);
        for (int i = 0; i < bound && !ir_already; i++) step();
        chk("wait_ir_timeout", ir_already, 1);
    endtask

    initial begin
        @(negedge clk);
        // zero-latency bus, DECODE always taking
        do_reset();
        rdy_mode = 1; resp_mode = 1; take_mode = 1;
        #1;
        chk("first_req", code_req, 1);
        chk("first_addr", code_addr_bus, 32'h0);
        chk("reset_ir", ir, 0);
        chk("reset_pc", pc_to_DECODE, 0);
        step(); step();
        #1;
        chk("stream_valid", ir_already, 1);
        chk("stream_pc0", pc_to_DECODE, 32'h0);
        chk("stream_addr2", code_addr_bus, 32'h8);
        repeat (8) step();
        #1;
        chk("stream_pc8", pc_to_DECODE, 32'h20);
        chk("stream_addr10", code_addr_bus, 32'h28);

        // DECODE stalled: queue fills to DEPTH then resumes at 0x10
        do_reset();
        rdy_mode = 1; resp_mode = 1; take_mode = 0;
        repeat (8) step();
        #1;
        chk("full_accepts", n_acc, 4);
        chk("full_req_low", code_req, 0);
        take_mode = 1;
        step();
        #1;
        chk("resume_req", code_req, 1);
        chk("resume_addr", code_addr_bus, 32'h10);
        chk("resume_pc", pc_to_DECODE, 32'h4);
        repeat (10) step();

        // redirect with three outstanding requests
        do_reset();
        rdy_mode = 1; resp_mode = 0; take_mode = 1;
        repeat (3) step();
        load_pc_en = 1; load_pc = 32'h100;
        step();
        load_pc_en = 0; resp_mode = 1;
        #1;
        chk("redir_req", code_req, 1);
        chk("redir_addr", code_addr_bus, 32'h100);
        chk("redir_empty", ir_already, 0);
        wait_ir(20);
        chk("redir_first_pc", pc_to_DECODE, 32'h100);
        repeat (4) step();

        // redirect coinciding with a response and a pop
        do_reset();
        rdy_mode = 1; resp_mode = 1; take_mode = 0;
        repeat (3) step();
        load_pc_en = 1; load_pc = 32'h203; take_mode = 1;
        step();
        load_pc_en = 0; rdy_mode = 0;
        #1;
        chk("redir2_addr", code_addr_bus, 32'h200);
        chk("redir2_req", code_req, 1);
        chk("redir2_empty", ir_already, 0);
        repeat (3) step();
        chk("redir2_still_empty", ir_already, 0);

        // response with nothing outstanding
        do_reset();
        step();
        spur = 1;
        step();
        spur = 0;
        #1;
        chk("spur_err", resp_err, 1);
        chk("spur_empty", ir_already, 0);
        repeat (3) step();
        chk("spur_sticky", resp_err, 1);
        do_reset();
        #1;
        chk("err_cleared", resp_err, 0);

        // address wrap
        load_pc_en = 1; load_pc = 32'hFFFF_FFFC;
        step();
        load_pc_en = 0; rdy_mode = 1; resp_mode = 1; take_mode = 1;
        #1;
        chk("wrap_addr0", code_addr_bus, 32'hFFFF_FFFC);
        step();
        #1;
        chk("wrap_addr1", code_addr_bus, 32'h0);
        wait_ir(10);
        chk("wrap_pc", pc_to_DECODE, 32'hFFFF_FFFC);

        // reset mid-stream
        repeat (3) step();
        reset = 1;
        step();
        reset = 0;
        #1;
        chk("midreset_addr", code_addr_bus, 32'h0);
        chk("midreset_req", code_req, 1);
        chk("midreset_empty", ir_already, 0);

        // randomized traffic
        rdy_mode = 2; resp_mode = 2; take_mode = 2;
        for (int c = 0; c < 3000; c++) begin
            load_pc_en = inflight.size() <= DEPTH && $urandom_range(0, 29) == 0;
            load_pc    = $urandom;
            reset      = $urandom_range(0, 299) == 0;
            step();
        end
        reset = 0; load_pc_en = 0;
        step();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
